// File: rtl/fusion_ctrl.sv
// Job sequencer for one fusion_unit: latches a job config, streams operand pairs, and
// accumulates the unit's psum into a signed dot product. Option: FUSION_CTRL_SAT_EN (saturate).
//
// state | meaning
// IDLE  | waiting for a job config (cfg_ready high once out of reset)
// RUN   | streaming operand beats until cfg_len beats are accepted
// DRAIN | last beat's psum is being accumulated
// DONE  | result offered on res_*; waits for res_ready
module fusion_ctrl #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_input_bitwidth,
  input  logic [2:0]       cfg_weight_bitwidth,
  input  logic [3:0]       cfg_input_sign,
  input  logic [3:0]       cfg_weight_sign,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_input,
  input  logic [31:0]      in_weight,
  output logic [2:0]       fu_input_bitwidth,
  output logic [2:0]       fu_weight_bitwidth,
  output logic [3:0]       fu_input_sign,
  output logic [3:0]       fu_weight_sign,
  output logic [31:0]      fu_input_forward,
  output logic [31:0]      fu_weight,
  input  logic [31:0]      fu_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_sat,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        cnt, len_q;
  logic                    beat_q;
  logic                    live_q;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic                    cfg_take, beat_take, cnt_lt;

  assign cnt_lt   = (cnt < len_q);
  assign res_data = acc;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // live_q keeps cfg_ready low while reset is asserted and for the first edge after it
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    cfg_take  = 1'b0;
    beat_take = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cfg_ready = live_q;
        if (cfg_valid && live_q) begin
          cfg_take  = 1'b1;
          state_nxt = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = cnt_lt;
        if (in_valid && cnt_lt) begin
          beat_take = 1'b1;
          if ((cnt + LEN_W'(1)) == len_q) state_nxt = DRAIN;
        end
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      live_q             <= 1'b0;
      fu_input_bitwidth  <= '0;
      fu_weight_bitwidth <= '0;
      fu_input_sign      <= '0;
      fu_weight_sign     <= '0;
      fu_input_forward   <= '0;
      fu_weight          <= '0;
      len_q              <= '0;
      cnt                <= '0;
      beat_q             <= 1'b0;
      acc                <= '0;
    end else begin
      live_q <= 1'b1;
      if (cfg_take) begin
        fu_input_bitwidth  <= cfg_input_bitwidth;
        fu_weight_bitwidth <= cfg_weight_bitwidth;
        fu_input_sign      <= cfg_input_sign;
        fu_weight_sign     <= cfg_weight_sign;
        len_q              <= cfg_len;
        cnt                <= '0;
        beat_q             <= 1'b0;
        acc                <= '0;
      end else begin
        beat_q <= beat_take;
        if (beat_take) begin
          fu_input_forward <= in_input;
          fu_weight        <= in_weight;
          cnt              <= cnt + LEN_W'(1);
        end
        if (beat_q) acc <= acc_nxt;
      end
    end
  end

`ifdef FUSION_CTRL_SAT_EN
  // Sum is formed one bit wider than both operands so overflow is visible before clamping
  localparam int SW = ((ACC_W > 32) ? ACC_W : 32) + 1;
  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;

  logic signed [SW-1:0] sum_w;
  logic                 clamp_hi, clamp_lo;
  logic                 sat_q;

  assign sum_w    = SW'(acc) + SW'($signed(fu_psum));
  assign clamp_hi = (sum_w > ACC_MAX);
  assign clamp_lo = (sum_w < ACC_MIN);
  assign acc_nxt  = clamp_hi ? ACC_MAX[ACC_W-1:0] :
                    clamp_lo ? ACC_MIN[ACC_W-1:0] : sum_w[ACC_W-1:0];

  always_ff @(posedge clk or posedge RST) begin
    if (RST)                                   sat_q <= 1'b0;
    else if (cfg_take)                         sat_q <= 1'b0;
    else if (beat_q && (clamp_hi || clamp_lo)) sat_q <= 1'b1;
  end

  assign res_sat = sat_q;
`else
  assign acc_nxt = acc + ACC_W'($signed(fu_psum));
  assign res_sat = 1'b0;
`endif

endmodule

// File: tb/tb_fusion_ctrl.sv
// Bench for fusion_ctrl: a 32-bit and a 16-bit accumulator build run side by side against
// a stand-in four-lane 8-bit fusion_unit and a job-level reference model.
module tb_fusion_ctrl;
  localparam int LEN_W = 8;
`ifdef FUSION_CTRL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  logic             cfg_valid = 1'b0;
  logic [2:0]       cfg_ibw = '0, cfg_wbw = '0;
  logic [3:0]       cfg_isg = '0, cfg_wsg = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_input = '0, in_weight = '0;
  logic             res_ready = 1'b0;

  logic        cfg_ready_a, in_ready_a, res_valid_a, res_sat_a, busy_a;
  logic [2:0]  fu_ibw_a, fu_wbw_a;
  logic [3:0]  fu_isg_a, fu_wsg_a;
  logic [31:0] fu_in_a, fu_w_a, psum_a, res_data_a;

  logic        cfg_ready_b, in_ready_b, res_valid_b, res_sat_b, busy_b;
  logic [2:0]  fu_ibw_b, fu_wbw_b;
  logic [3:0]  fu_isg_b, fu_wsg_b;
  logic [31:0] fu_in_b, fu_w_b, psum_b;
  logic [15:0] res_data_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] job_a [256];
  logic [31:0] job_w [256];
  logic [2:0]  bw_codes [3] = '{3'b001, 3'b010, 3'b100};

  // Stand-in fusion_unit: four 8-bit lanes, lane i signed when sign bit (3-i) is set
  function automatic longint lane_dot(logic [31:0] a, logic [31:0] w, logic [3:0] si, logic [3:0] sw);
    longint s, av, wv;
    logic [7:0] ab, wb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ab = a[8*i +: 8];
      wb = w[8*i +: 8];
      av = si[3-i] ? longint'($signed(ab)) : longint'(ab);
      wv = sw[3-i] ? longint'($signed(wb)) : longint'(wb);
      s += av * wv;
    end
    return s;
  endfunction

  assign psum_a = 32'(lane_dot(fu_in_a, fu_w_a, fu_isg_a, fu_wsg_a));
  assign psum_b = 32'(lane_dot(fu_in_b, fu_w_b, fu_isg_b, fu_wsg_b));

  fusion_ctrl #(.LEN_W(LEN_W), .ACC_W(32)) dut_a (
    .clk(clk), .RST(RST),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
    .cfg_input_bitwidth(cfg_ibw), .cfg_weight_bitwidth(cfg_wbw),
    .cfg_input_sign(cfg_isg), .cfg_weight_sign(cfg_wsg), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_input(in_input), .in_weight(in_weight),
    .fu_input_bitwidth(fu_ibw_a), .fu_weight_bitwidth(fu_wbw_a),
    .fu_input_sign(fu_isg_a), .fu_weight_sign(fu_wsg_a),
    .fu_input_forward(fu_in_a), .fu_weight(fu_w_a), .fu_psum(psum_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
    .res_sat(res_sat_a), .busy(busy_a)
  );

  fusion_ctrl #(.LEN_W(LEN_W), .ACC_W(16)) dut_b (
    .clk(clk), .RST(RST),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
    .cfg_input_bitwidth(cfg_ibw), .cfg_weight_bitwidth(cfg_wbw),
    .cfg_input_sign(cfg_isg), .cfg_weight_sign(cfg_wsg), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_input(in_input), .in_weight(in_weight),
    .fu_input_bitwidth(fu_ibw_b), .fu_weight_bitwidth(fu_wbw_b),
    .fu_input_sign(fu_isg_b), .fu_weight_sign(fu_wsg_b),
    .fu_input_forward(fu_in_b), .fu_weight(fu_w_b), .fu_psum(psum_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
    .res_sat(res_sat_b), .busy(busy_b)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Job result: running sum of lane dot products, wrapped to accw bits or clamped per beat
  function automatic void model(int len, logic [3:0] si, logic [3:0] sw, int accw,
                                output longint res, output bit sat);
    longint mx, mn;
    mx = (longint'(1) <<< (accw - 1)) - 1;
    mn = -mx - 1;
    res = 0;
    sat = 1'b0;
    for (int k = 0; k < len; k++) begin
      res += lane_dot(job_a[k], job_w[k], si, sw);
      if (SAT_EN) begin
        if (res > mx) begin res = mx; sat = 1'b1; end
        else if (res < mn) begin res = mn; sat = 1'b1; end
      end
    end
  endfunction

  task automatic check_idle_zero(string tag);
    chk({tag, ".cfg_ready"}, cfg_ready_a, 0);
    chk({tag, ".in_ready"}, in_ready_a, 0);
    chk({tag, ".res_valid"}, res_valid_a, 0);
    chk({tag, ".res_data"}, res_data_a, 0);
    chk({tag, ".res_sat"}, res_sat_a, 0);
    chk({tag, ".busy"}, busy_a, 0);
    chk({tag, ".fu_in"}, fu_in_a, 0);
    chk({tag, ".fu_w"}, fu_w_a, 0);
    chk({tag, ".fu_cfg"}, {fu_ibw_a, fu_wbw_a, fu_isg_a, fu_wsg_a}, 0);
    chk({tag, ".b_busy"}, {busy_b, res_valid_b, cfg_ready_b}, 0);
    chk({tag, ".b_res_data"}, res_data_b, 0);
  endtask

  // rnd_gap: gaps before each beat drawn from 0..gap; otherwise exactly gap between beats
  task automatic run_job(string tag, int len, logic [2:0] ibw, logic [2:0] wbw,
                         logic [3:0] isg, logic [3:0] wsg, int gap, bit rnd_gap, int bp);
    longint r32, r16;
    bit s32, s16;
    int g;
    model(len, isg, wsg, 32, r32, s32);
    model(len, isg, wsg, 16, r16, s16);
    cfg_valid = 1'b1;
    cfg_ibw = ibw; cfg_wbw = wbw; cfg_isg = isg; cfg_wsg = wsg;
    cfg_len = LEN_W'(len);
    chk({tag, ".cfg_ready"}, cfg_ready_a, 1);
    tick();
    cfg_valid = 1'b0;
    cfg_ibw = 3'($urandom); cfg_wbw = 3'($urandom);
    cfg_isg = 4'($urandom); cfg_wsg = 4'($urandom);
    cfg_len = LEN_W'($urandom);
    chk({tag, ".fu_cfg"}, {fu_ibw_a, fu_wbw_a, fu_isg_a, fu_wsg_a}, {ibw, wbw, isg, wsg});
    chk({tag, ".busy"}, busy_a, 1);
    chk({tag, ".cfg_ready_busy"}, cfg_ready_a, 0);
    if (len == 0) begin
      chk({tag, ".len0_in_ready"}, in_ready_a, 0);
    end else begin
      for (int k = 0; k < len; k++) begin
        g = rnd_gap ? int'($urandom_range(0, gap)) : ((k == 0) ? 0 : gap);
        repeat (g) begin
          in_valid = 1'b0;
          in_input = $urandom;
          in_weight = $urandom;
          tick();
        end
        in_valid = 1'b1;
        in_input = job_a[k];
        in_weight = job_w[k];
        chk({tag, ".in_ready"}, {in_ready_a, in_ready_b}, 2'b11);
        chk({tag, ".no_res"}, res_valid_a, 0);
        tick();
      end
      in_valid = 1'b0;
      in_input = $urandom;
      in_weight = $urandom;
      chk({tag, ".drain_res_valid"}, res_valid_a, 0);
      chk({tag, ".drain_in_ready"}, in_ready_a, 0);
      tick();
    end
    chk({tag, ".res_valid"}, {res_valid_a, res_valid_b}, 2'b11);
    chk({tag, ".res_data32"}, res_data_a, r32[31:0]);
    chk({tag, ".res_data16"}, res_data_b, r16[15:0]);
    chk({tag, ".res_sat32"}, res_sat_a, s32);
    chk({tag, ".res_sat16"}, res_sat_b, s16);
    repeat (bp) begin
      cfg_valid = 1'b1;
      cfg_len = LEN_W'(1);
      in_valid = 1'b1;
      tick();
      chk({tag, ".bp_valid"}, {res_valid_a, res_valid_b}, 2'b11);
      chk({tag, ".bp_data"}, {res_data_a, res_data_b}, {r32[31:0], r16[15:0]});
      chk({tag, ".bp_sat"}, {res_sat_a, res_sat_b}, {s32, s16});
      chk({tag, ".bp_ready"}, {cfg_ready_a, in_ready_a}, 2'b00);
    end
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, ".back_idle"}, {busy_a, res_valid_a, cfg_ready_a}, 3'b001);
    chk({tag, ".back_idle_b"}, {busy_b, res_valid_b, cfg_ready_b}, 3'b001);
  endtask

  initial begin
    int len;
    #2;
    check_idle_zero("reset");
    tick();
    RST = 1'b0;
    tick();
    chk("reset.cfg_ready_after", cfg_ready_a, 1);

    job_a[0] = 32'h0000_0003; job_w[0] = 32'h0707_0707;
    run_job("t1_len1", 1, 3'b100, 3'b100, 4'h0, 4'h0, 0, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin job_a[k] = 32'd13; job_w[k] = 32'h0a0a_0a0a; end
    run_job("t2_len4_bp5", 4, 3'b100, 3'b100, 4'h0, 4'h0, 0, 1'b0, 5);

    for (int k = 0; k < 2; k++) begin job_a[k] = 32'hffff_ff80; job_w[k] = 32'd127; end
    run_job("t3_signed_gap", 2, 3'b100, 3'b100, 4'h8, 4'h0, 3, 1'b0, 0);

    run_job("t5_len0", 0, 3'b001, 3'b010, 4'h3, 4'hc, 0, 1'b0, 2);

    for (int k = 0; k < 3; k++) begin job_a[k] = 32'd127; job_w[k] = 32'd127; end
    run_job("t6_127sq", 3, 3'b100, 3'b100, 4'h0, 4'h0, 0, 1'b0, 1);

    for (int k = 0; k < 255; k++) begin job_a[k] = $urandom; job_w[k] = $urandom; end
    run_job("max_len", 255, 3'b100, 3'b100, 4'h5, 4'ha, 0, 1'b0, 0);

    for (int j = 0; j < 12; j++) begin
      len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin job_a[k] = $urandom; job_w[k] = $urandom; end
      run_job($sformatf("rand%0d", j), len, bw_codes[$urandom_range(0, 2)],
              bw_codes[$urandom_range(0, 2)], 4'($urandom), 4'($urandom),
              2, 1'b1, int'($urandom_range(0, 3)));
    end

    // Abort mid-job: reset after the second of four beats
    cfg_valid = 1'b1; cfg_ibw = 3'b100; cfg_wbw = 3'b100; cfg_isg = 4'hf; cfg_wsg = 4'h1;
    cfg_len = LEN_W'(4);
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_input = 32'h1234_5678 + k; in_weight = 32'h0102_0304;
      tick();
    end
    in_valid = 1'b0;
    chk("abort.busy_before", busy_a, 1);
    RST = 1'b1;
    #1;
    check_idle_zero("abort");
    tick();
    RST = 1'b0;
    tick();
    chk("abort.after_release", {busy_a, res_valid_a, cfg_ready_a}, 3'b001);
    job_a[0] = 32'h0000_0005; job_w[0] = 32'h0000_0009;
    run_job("post_abort", 1, 3'b010, 3'b001, 4'h0, 4'h0, 1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
